// File: rtl/fetch_pkg.sv
// Shared constants and entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer with synchronous clear and same-cycle push/pop.
// Latency: a push is visible at the head one cycle later; push into a full buffer is dropped unless a pop frees room.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request in flight, buffers {pc, inst} toward decode.
// Redirects flush the buffer and discard any response still owed to the old path.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              imem_req_valid,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fault_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            outstanding;
  logic            drop;
  logic            fault;

  logic [CW-1:0]   count;
  logic            reserved;
  logic            space_ok;
  logic            req_fire;
  logic            resp_hit;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  // The in-flight word already owns a buffer slot unless it is going to be dropped.
  assign reserved = outstanding && !drop;
  assign space_ok = (count + CW'(reserved)) < CW'(DEPTH);

  assign imem_req_valid = !fault && !redirect_valid
                        && (!outstanding || imem_resp_valid) && space_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_hit   = imem_resp_valid && outstanding;
  assign push       = resp_hit && !drop && !redirect_valid;
  assign push_entry = '{pc: req_pc, inst: imem_resp_data};

  assign inst_valid       = (count != '0);
  assign pop              = inst_valid && inst_ready;
  assign inst_pc          = head_entry.pc;
  assign inst_data        = head_entry.inst;
  assign fault_misaligned = fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      fault       <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_target;
      fault       <= |redirect_target[1:0];
      // A response landing in this cycle is simply lost; only a still-pending one needs dropping.
      outstanding <= outstanding && !imem_resp_valid;
      drop        <= outstanding && !imem_resp_valid;
    end else begin
      if (resp_hit) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= pc;
        pc          <= pc + XLEN'(PC_INC);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model, epoch-tagged expected stream.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fault_misaligned;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .fault_misaligned (fault_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          epoch = 0;
  bit          mfault = 0;
  logic [31:0] req_exp = RPC;
  bit          slot_busy = 0;
  logic [31:0] slot_addr;
  logic [31:0] slot_pc;
  int          slot_ep;
  int          slot_due;
  int          fixed_lat = 1;
  bit          rdy_rand = 0;
  int          npops = 0;
  int          nhs = 0;
  logic [31:0] last_pop_pc;
  bit          resp_now;
  bit          exp_rv;
  bit          hs;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side: one response per accepted request, returned after its latency.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_resp_valid = slot_busy && (slot_due == cyc);
    imem_resp_data  = imem_resp_valid ? mem_word(slot_addr) : $urandom;
    imem_req_ready  = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor and reference model: requests on the current path are tagged with an epoch;
  // only responses whose epoch survives to arrival (and not in a redirect cycle) reach decode.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      slot_busy = 0;
      epoch++;
      mfault  = 0;
      req_exp = RPC;
    end else begin
      resp_now = slot_busy && (slot_due == cyc);
      exp_rv = !mfault && !redirect_valid && (!slot_busy || resp_now)
               && ((q.size() + ((slot_busy && slot_ep == epoch) ? 1 : 0)) < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("fault", 32'(fault_misaligned), 32'(mfault));
      check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      if (inst_valid && q.size() != 0) begin
        check("inst_pc", inst_pc, q[0].pc);
        check("inst_data", inst_data, q[0].inst);
      end
      hs = imem_req_valid && imem_req_ready;
      if (hs) check("req_addr", imem_req_addr, req_exp);

      if (inst_valid && inst_ready && q.size() != 0) begin
        last_pop_pc = inst_pc;
        popped.push_back(inst_pc);
        q.pop_front();
        npops++;
      end
      if (resp_now) begin
        if (slot_ep == epoch && !redirect_valid) q.push_back('{slot_pc, mem_word(slot_pc)});
        slot_busy = 0;
      end
      if (hs) begin
        slot_busy = 1;
        slot_addr = imem_req_addr;
        slot_pc   = req_exp;
        slot_ep   = epoch;
        slot_due  = cyc + ((fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4));
        req_exp   = req_exp + 32'd4;
        nhs++;
      end
      if (redirect_valid) begin
        epoch++;
        q.delete();
        req_exp = redirect_target;
        mfault  = (redirect_target[1:0] != 2'b00);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick(1);
    redirect_valid  = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp);
    int n0;
    int k;
    n0 = npops;
    k  = 0;
    while (npops == n0 && k < 200) begin
      tick(1);
      k++;
    end
    if (npops == n0) begin
      errors++;
      checks++;
      $display("FAIL %s: no instruction delivered within 200 cycles, expected pc %h", name, exp);
    end else begin
      check(name, last_pop_pc, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n0;
    int h0;
    int k;
    bit prev_redir;
    logic [31:0] t;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;

    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    tick(3);
    check("reset_inst_valid", 32'(inst_valid), 32'd0);
    check("reset_fault", 32'(fault_misaligned), 32'd0);
    reset = 1'b0;

    // Streaming with a 1-cycle memory.
    tick(2);
    check("first_two_requests", 32'(nhs), 32'd2);
    n0 = npops;
    tick(20);
    check("throughput", 32'(npops - n0), 32'd20);
    p0 = popped[0];
    p1 = popped[1];
    p2 = popped[2];
    check("first_pc0", p0, 32'h0);
    check("first_pc1", p1, 32'h4);
    check("first_pc2", p2, 32'h8);

    // Fill the buffer with decode stalled, then release exactly one slot.
    inst_ready = 1'b0;
    do_reset();
    h0 = nhs;
    tick(12);
    check("fill_requests", 32'(nhs - h0), 32'd4);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    check("full_head_pc", inst_pc, RPC);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    h0 = nhs;
    tick(8);
    check("refill_one", 32'(nhs - h0), 32'd1);
    inst_ready = 1'b1;

    // 3-cycle memory: redirect while 0x8 is in flight.
    fixed_lat = 3;
    do_reset();
    k = 0;
    while (!(slot_busy && slot_pc == 32'h8) && k < 50) begin
      tick(1);
      k++;
    end
    check("saw_req_0x8", 32'(slot_busy && slot_pc == 32'h8), 32'd1);
    redirect_to(32'h100);
    wait_pop("redirect_inflight", 32'h100);

    // Redirect in the cycle a response arrives.
    k = 0;
    while (!imem_resp_valid && k < 50) begin
      tick(1);
      k++;
    end
    check("saw_response", 32'(imem_resp_valid), 32'd1);
    redirect_to(32'h300);
    wait_pop("redirect_on_resp", 32'h300);

    // Misaligned target halts fetch until an aligned redirect.
    fixed_lat = 1;
    redirect_to(32'h102);
    check("fault_set", 32'(fault_misaligned), 32'd1);
    h0 = nhs;
    tick(6);
    check("fault_no_requests", 32'(nhs - h0), 32'd0);
    check("fault_held", 32'(fault_misaligned), 32'd1);
    redirect_to(32'h200);
    check("fault_cleared", 32'(fault_misaligned), 32'd0);
    wait_pop("resume_0x200", 32'h200);

    // PC wrap-around.
    redirect_to(32'hFFFF_FFFC);
    wait_pop("wrap_top", 32'hFFFF_FFFC);
    wait_pop("wrap_zero", 32'h0);

    // Reset in the middle of a stream.
    tick(3);
    do_reset();
    check("midreset_inst_valid", 32'(inst_valid), 32'd0);
    check("midreset_req_valid", 32'(imem_req_valid), 32'd1);
    check("midreset_req_addr", imem_req_addr, RPC);

    // Randomized traffic: variable latency, stalls, redirects, occasional reset.
    rdy_rand   = 1'b1;
    fixed_lat  = 0;
    prev_redir = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      reset          = ($urandom_range(0, 499) == 0);
      redirect_valid = 1'b0;
      if (!prev_redir && $urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, 9);
        t = $urandom;
        if (k == 0) begin
          t[1:0] = 2'b10;
        end else if (k == 1) begin
          t = 32'hFFFF_FFF0;
        end else begin
          t = t & 32'h0000_FFFC;
        end
        redirect_valid  = 1'b1;
        redirect_target = t;
      end
      prev_redir = redirect_valid;
      tick(1);
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_to(32'h400);
    rdy_rand   = 1'b0;
    inst_ready = 1'b1;
    wait_pop("final_resume", 32'h400);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
